// File: rtl/truth_table_sweeper_pkg.sv
// Shared types for the truth-table sweeper: row index, table code and sweep FSM states.
package truth_table_pkg;

    localparam int N_IN = 3;
    localparam int ROWS = 8;

    typedef logic [ROWS-1:0] tt_code_t;
    typedef logic [N_IN-1:0] row_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } sweep_state_t;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Host/gate-facing signals of the sweeper; master = sweeper side, slave = host/gate side.
interface truth_table_sweeper_if;

    logic                      start;
    logic                      abort;
    logic                      dut_out;
    logic                      in1;
    logic                      in2;
    logic                      in3;
    logic                      busy;
    logic                      done;
    logic                      table_valid;
    truth_table_pkg::tt_code_t table_code;

    modport master (
        input  start, abort, dut_out,
        output in1, in2, in3, busy, done, table_valid, table_code
    );

    modport slave (
        output start, abort, dut_out,
        input  in1, in2, in3, busy, done, table_valid, table_code
    );

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter; load wins over enable, zero flag is combinational from the count.
// Counts one per enabled edge; no flow control.
module settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a 3-input gate through rows 000..111, holding each SETTLE_CYCLES, and builds its 8-bit code.
// Sweep takes 8*SETTLE_CYCLES+1 cycles from start; SWEEP_MAJORITY_EN votes 3 samples per row.
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    truth_table_sweeper_if.master  sw
);

    sweep_state_t     state_q, state_d;
    row_idx_t         row_q, row_d;
    tt_code_t         shadow_q, shadow_d;
    tt_code_t         table_q, table_d;
    logic             table_valid_q, table_valid_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             cnt_load;
    logic             cnt_en;
    logic             sample_bit;

    settle_timer #(.CNT_W(CNT_W)) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .en       (cnt_en),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

`ifdef SWEEP_MAJORITY_EN
    if (SETTLE_CYCLES < 3) begin : g_maj_cfg_check
        $error("SWEEP_MAJORITY_EN needs SETTLE_CYCLES >= 3");
    end

    // Early samples at count 2 and 1; the count-0 sample is taken live at the commit edge.
    logic [1:0] samp_q, samp_d;

    always_comb begin
        samp_d = samp_q;
        if (state_q == RUN) begin
            if (cnt == CNT_W'(2)) samp_d[1] = sw.dut_out;
            if (cnt == CNT_W'(1)) samp_d[0] = sw.dut_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q <= '0;
        end else begin
            samp_q <= samp_d;
        end
    end

    assign sample_bit = (samp_q[1] & samp_q[0]) | (samp_q[1] & sw.dut_out) | (samp_q[0] & sw.dut_out);
`else
    assign sample_bit = sw.dut_out;
`endif

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        shadow_d      = shadow_q;
        table_d       = table_q;
        table_valid_d = table_valid_q;
        done_d        = 1'b0;
        busy_d        = busy_q;
        cnt_load      = 1'b0;
        cnt_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (sw.start && !sw.abort) begin
                    state_d       = RUN;
                    row_d         = '0;
                    busy_d        = 1'b1;
                    table_valid_d = 1'b0;
                    cnt_load      = 1'b1;
                end
            end
            RUN: begin
                if (sw.abort) begin
                    state_d = IDLE;
                    row_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_en = (cnt != '0);
                    if (cnt_zero) begin
                        shadow_d[3'd7 - row_q] = sample_bit;
                        if (row_q == 3'd7) begin
                            // Commit on entry to FIN so table is valid alongside done.
                            state_d       = FIN;
                            table_d       = shadow_d;
                            table_valid_d = 1'b1;
                            done_d        = 1'b1;
                        end else begin
                            row_d    = row_q + 3'd1;
                            cnt_load = 1'b1;
                        end
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                row_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            row_q         <= '0;
            shadow_q      <= '0;
            table_q       <= '0;
            table_valid_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            shadow_q      <= shadow_d;
            table_q       <= table_d;
            table_valid_q <= table_valid_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign sw.in1         = row_q[2];
    assign sw.in2         = row_q[1];
    assign sw.in3         = row_q[0];
    assign sw.busy        = busy_q;
    assign sw.done        = done_q;
    assign sw.table_valid = table_valid_q;
    assign sw.table_code  = table_q;

endmodule
